// File: rtl/id_ex_pipeline_bank_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-word layout,
// the NOP control word, FSM states and per-edge action codes.
package id_ex_pkg;

  localparam int unsigned CTRL_W = 15;

  // Control-word bit offsets (LSB of each field), MSB first:
  // RegDst, RegWrite, ALUSrc, ALUOp[2], MemRead, MemWrite, MemtoReg,
  // ALUCtrl[4], select_bytes[3]
  localparam int unsigned CTRL_REGDST     = 14;
  localparam int unsigned CTRL_REGWRITE   = 13;
  localparam int unsigned CTRL_ALUSRC     = 12;
  localparam int unsigned CTRL_ALUOP      = 10;
  localparam int unsigned CTRL_MEMREAD    = 9;
  localparam int unsigned CTRL_MEMWRITE   = 8;
  localparam int unsigned CTRL_MEMTOREG   = 7;
  localparam int unsigned CTRL_ALUCTRL    = 3;
  localparam int unsigned CTRL_SELBYTES   = 0;

  localparam logic [3:0] ALUCTRL_ADD = 4'b0010;

  // Harmless ADD with every side-effect bit cleared
  localparam logic [CTRL_W-1:0] NOP_CTRL = 15'b000000000010000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_LOAD  = 2'd1,
    ACT_NOP   = 2'd2,
    ACT_FLUSH = 2'd3
  } action_t;

endpackage

// File: rtl/id_ex_pipeline_bank_if.sv
// Decode-to-execute bundle: decode-side inputs and registered EX-side outputs.
interface id_ex_pipeline_bank_if #(
  parameter int unsigned CANT_BITS_REGISTROS = 32,
  parameter int unsigned CANT_BITS_ADDR      = 11,
  parameter int unsigned CANT_BITS_REG_ADDR  = 5,
  parameter int unsigned CANT_BITS_CTRL      = 15,
  parameter int unsigned CANT_BITS_CONTADOR  = 16
);
  logic                           i_enable_pipeline;
  logic                           i_valid;
  logic                           i_bubble;
  logic                           i_flush;
  logic                           i_halt;
  logic [CANT_BITS_REGISTROS-1:0] i_data_A;
  logic [CANT_BITS_REGISTROS-1:0] i_data_B;
  logic [CANT_BITS_REGISTROS-1:0] i_imm;
  logic [CANT_BITS_REG_ADDR-1:0]  i_rs;
  logic [CANT_BITS_REG_ADDR-1:0]  i_rt;
  logic [CANT_BITS_REG_ADDR-1:0]  i_rd;
  logic [CANT_BITS_ADDR-1:0]      i_pc;
  logic [CANT_BITS_CTRL-1:0]      i_ctrl;

  logic [CANT_BITS_REGISTROS-1:0] o_data_A;
  logic [CANT_BITS_REGISTROS-1:0] o_data_B;
  logic [CANT_BITS_REGISTROS-1:0] o_imm;
  logic [CANT_BITS_REG_ADDR-1:0]  o_rs;
  logic [CANT_BITS_REG_ADDR-1:0]  o_rt;
  logic [CANT_BITS_REG_ADDR-1:0]  o_rd;
  logic [CANT_BITS_ADDR-1:0]      o_pc;
  logic [CANT_BITS_CTRL-1:0]      o_ctrl;
  logic                           o_valid;
  logic                           o_halt_detected;
  logic                           o_halted;
  logic [1:0]                     o_state;
  logic [CANT_BITS_CONTADOR-1:0]  o_bubble_count;
  logic [CANT_BITS_CONTADOR-1:0]  o_flush_count;

  modport master (
    output i_enable_pipeline, i_valid, i_bubble, i_flush, i_halt,
           i_data_A, i_data_B, i_imm, i_rs, i_rt, i_rd, i_pc, i_ctrl,
    input  o_data_A, o_data_B, o_imm, o_rs, o_rt, o_rd, o_pc, o_ctrl,
           o_valid, o_halt_detected, o_halted, o_state,
           o_bubble_count, o_flush_count
  );

  modport slave (
    input  i_enable_pipeline, i_valid, i_bubble, i_flush, i_halt,
           i_data_A, i_data_B, i_imm, i_rs, i_rt, i_rd, i_pc, i_ctrl,
    output o_data_A, o_data_B, o_imm, o_rs, o_rt, o_rd, o_pc, o_ctrl,
           o_valid, o_halt_detected, o_halted, o_state,
           o_bubble_count, o_flush_count
  );
endinterface

// File: rtl/id_ex_pipeline_bank_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_soft_reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  // Count events on the falling edge, saturating at all-ones
  always_ff @(negedge i_clock) begin
    if (i_soft_reset) begin
      o_count <= '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipeline_bank.sv
// ID/EX pipeline register with stall/bubble/flush handling, a HALT drain
// state machine and saturating bubble/flush statistics.
module id_ex_pipeline_bank
  import id_ex_pkg::*;
#(
  parameter int unsigned CANT_BITS_REGISTROS = 32,
  parameter int unsigned CANT_BITS_ADDR      = 11,
  parameter int unsigned CANT_BITS_REG_ADDR  = 5,
  parameter int unsigned CANT_BITS_CTRL      = 15,
  parameter logic [CANT_BITS_CTRL-1:0] NOP_CTRL = CANT_BITS_CTRL'(id_ex_pkg::NOP_CTRL),
  parameter int unsigned HALT_DRAIN_CYCLES   = 3,
  parameter int unsigned CANT_BITS_CONTADOR  = 16
) (
  input  logic                   i_clock,
  input  logic                   i_soft_reset,
  id_ex_pipeline_bank_if.slave   bus
);

  localparam int unsigned DRAIN_W =
    (HALT_DRAIN_CYCLES < 2) ? 1 : $clog2(HALT_DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(HALT_DRAIN_CYCLES);

  state_t             state_q, state_n;
  logic [DRAIN_W-1:0] drain_q, drain_n;
  action_t            act;
  logic               bubble_inc;
  logic               flush_inc;

  // FSM and drain-counter register
  always_ff @(negedge i_clock) begin
    if (i_soft_reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_n;
      drain_q <= drain_n;
    end
  end

  // Next state and per-edge action; a stall or HALTED leaves act at HOLD
  always_comb begin
    state_n    = state_q;
    drain_n    = drain_q;
    act        = ACT_HOLD;
    bubble_inc = 1'b0;
    flush_inc  = 1'b0;
    if (bus.i_enable_pipeline) begin
      case (state_q)
        ST_RUN: begin
          if (bus.i_flush) begin
            act       = ACT_FLUSH;
            flush_inc = 1'b1;
          end else if (bus.i_bubble) begin
            act        = ACT_NOP;
            bubble_inc = 1'b1;
          end else begin
            act = ACT_LOAD;
            if (bus.i_valid && bus.i_halt) begin
              if (HALT_DRAIN_CYCLES == 0) begin
                state_n = ST_HALTED;
              end else begin
                state_n = ST_DRAIN;
                drain_n = DRAIN_INIT;
              end
            end
          end
        end
        ST_DRAIN: begin
          act     = ACT_NOP;
          drain_n = drain_q - DRAIN_W'(1);
          if (drain_q == DRAIN_W'(1)) begin
            state_n = ST_HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline register fields
  always_ff @(negedge i_clock) begin
    if (i_soft_reset) begin
      bus.o_data_A        <= '0;
      bus.o_data_B        <= '0;
      bus.o_imm           <= '0;
      bus.o_rs            <= '0;
      bus.o_rt            <= '0;
      bus.o_rd            <= '0;
      bus.o_pc            <= '0;
      bus.o_ctrl          <= NOP_CTRL;
      bus.o_valid         <= 1'b0;
      bus.o_halt_detected <= 1'b0;
    end else begin
      case (act)
        ACT_LOAD: begin
          bus.o_data_A        <= bus.i_data_A;
          bus.o_data_B        <= bus.i_data_B;
          bus.o_imm           <= bus.i_imm;
          bus.o_rs            <= bus.i_rs;
          bus.o_rt            <= bus.i_rt;
          bus.o_rd            <= bus.i_rd;
          bus.o_pc            <= bus.i_pc;
          bus.o_ctrl          <= bus.i_ctrl;
          bus.o_valid         <= bus.i_valid;
          bus.o_halt_detected <= bus.i_valid & bus.i_halt;
        end
        ACT_NOP: begin
          bus.o_ctrl          <= NOP_CTRL;
          bus.o_valid         <= 1'b0;
          bus.o_halt_detected <= 1'b0;
        end
        ACT_FLUSH: begin
          bus.o_data_A        <= '0;
          bus.o_data_B        <= '0;
          bus.o_imm           <= '0;
          bus.o_rs            <= '0;
          bus.o_rt            <= '0;
          bus.o_rd            <= '0;
          bus.o_pc            <= '0;
          bus.o_ctrl          <= NOP_CTRL;
          bus.o_valid         <= 1'b0;
          bus.o_halt_detected <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Status outputs come straight from the state register
  always_comb begin
    bus.o_state  = state_q;
    bus.o_halted = (state_q == ST_HALTED);
  end

  sat_counter #(.WIDTH(CANT_BITS_CONTADOR)) u_bubble_cnt (
    .i_clock      (i_clock),
    .i_soft_reset (i_soft_reset),
    .i_inc        (bubble_inc),
    .o_count      (bus.o_bubble_count)
  );

  sat_counter #(.WIDTH(CANT_BITS_CONTADOR)) u_flush_cnt (
    .i_clock      (i_clock),
    .i_soft_reset (i_soft_reset),
    .i_inc        (flush_inc),
    .o_count      (bus.o_flush_count)
  );

endmodule

// File: tb/tb_id_ex_pipeline_bank.sv
// Self-checking bench for id_ex_pipeline_bank: directed table, hand-written
// HALT/flush/saturation sequences and a randomized run against a model.
module tb_id_ex_pipeline_bank;

  localparam logic [14:0] NOP = 15'b000000000010000;
  localparam int HDC1 = 3;
  localparam int CMAX1 = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  int n_checks = 0;
  int n_fail = 0;

  id_ex_pipeline_bank_if #(.CANT_BITS_CONTADOR(16)) bus1 ();
  id_ex_pipeline_bank_if #(.CANT_BITS_CONTADOR(4))  bus2 ();

  id_ex_pipeline_bank #(.HALT_DRAIN_CYCLES(3), .CANT_BITS_CONTADOR(16)) dut1 (
    .i_clock      (clk),
    .i_soft_reset (rst1),
    .bus          (bus1.slave)
  );

  id_ex_pipeline_bank #(.HALT_DRAIN_CYCLES(0), .CANT_BITS_CONTADOR(4)) dut2 (
    .i_clock      (clk),
    .i_soft_reset (rst2),
    .bus          (bus2.slave)
  );

  // State updates on the falling edge; sample 1 time unit later
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive1(input logic en, input logic v, input logic b, input logic f,
                        input logic h, input logic [31:0] da, input logic [4:0] rd,
                        input logic [14:0] ctrl);
    bus1.i_enable_pipeline = en;
    bus1.i_valid  = v;
    bus1.i_bubble = b;
    bus1.i_flush  = f;
    bus1.i_halt   = h;
    bus1.i_data_A = da;
    bus1.i_data_B = ~da;
    bus1.i_imm    = da ^ 32'h0F0F_0F0F;
    bus1.i_rs     = rd ^ 5'd1;
    bus1.i_rt     = rd ^ 5'd2;
    bus1.i_rd     = rd;
    bus1.i_pc     = da[10:0];
    bus1.i_ctrl   = ctrl;
  endtask

  task automatic drive2(input logic en, input logic v, input logic f, input logic h,
                        input logic [31:0] da, input logic [14:0] ctrl);
    bus2.i_enable_pipeline = en;
    bus2.i_valid  = v;
    bus2.i_bubble = 1'b0;
    bus2.i_flush  = f;
    bus2.i_halt   = h;
    bus2.i_data_A = da;
    bus2.i_data_B = da;
    bus2.i_imm    = da;
    bus2.i_rs     = 5'd1;
    bus2.i_rt     = 5'd2;
    bus2.i_rd     = 5'd3;
    bus2.i_pc     = 11'd4;
    bus2.i_ctrl   = ctrl;
  endtask

  // Reference model of dut1: a transcription of the action priority list
  logic [31:0] m_da, m_db, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [10:0] m_pc;
  logic [14:0] m_ctrl;
  logic        m_v, m_hd;
  int m_mode;   // 0 run, 1 draining, 2 halted
  int m_left;   // NOPs still owed
  int m_bc, m_fc;

  task automatic model_reset();
    m_da = '0; m_db = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_pc = '0;
    m_ctrl = NOP; m_v = 1'b0; m_hd = 1'b0;
    m_mode = 0; m_left = 0; m_bc = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    if (rst1) begin
      model_reset();
    end else if (m_mode == 2 || !bus1.i_enable_pipeline) begin
      // frozen
    end else if (m_mode == 1) begin
      m_ctrl = NOP; m_v = 1'b0; m_hd = 1'b0;
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 2;
    end else if (bus1.i_flush) begin
      m_da = '0; m_db = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_pc = '0;
      m_ctrl = NOP; m_v = 1'b0; m_hd = 1'b0;
      if (m_fc < CMAX1) m_fc = m_fc + 1;
    end else if (bus1.i_bubble) begin
      m_ctrl = NOP; m_v = 1'b0; m_hd = 1'b0;
      if (m_bc < CMAX1) m_bc = m_bc + 1;
    end else begin
      m_da = bus1.i_data_A; m_db = bus1.i_data_B; m_imm = bus1.i_imm;
      m_rs = bus1.i_rs; m_rt = bus1.i_rt; m_rd = bus1.i_rd; m_pc = bus1.i_pc;
      m_ctrl = bus1.i_ctrl; m_v = bus1.i_valid; m_hd = bus1.i_valid & bus1.i_halt;
      if (m_hd) begin
        m_mode = (HDC1 == 0) ? 2 : 1;
        m_left = HDC1;
      end
    end
  endtask

  task automatic check_all();
    chk("rand_data_A", bus1.o_data_A, m_da);
    chk("rand_data_B", bus1.o_data_B, m_db);
    chk("rand_imm", bus1.o_imm, m_imm);
    chk("rand_rs", 32'(bus1.o_rs), 32'(m_rs));
    chk("rand_rt", 32'(bus1.o_rt), 32'(m_rt));
    chk("rand_rd", 32'(bus1.o_rd), 32'(m_rd));
    chk("rand_pc", 32'(bus1.o_pc), 32'(m_pc));
    chk("rand_ctrl", 32'(bus1.o_ctrl), 32'(m_ctrl));
    chk("rand_valid", 32'(bus1.o_valid), 32'(m_v));
    chk("rand_halt_det", 32'(bus1.o_halt_detected), 32'(m_hd));
    chk("rand_state", 32'(bus1.o_state), 32'(m_mode));
    chk("rand_halted", 32'(bus1.o_halted), (m_mode == 2) ? 32'd1 : 32'd0);
    chk("rand_bubble_cnt", 32'(bus1.o_bubble_count), 32'(m_bc));
    chk("rand_flush_cnt", 32'(bus1.o_flush_count), 32'(m_fc));
  endtask

  typedef struct {
    logic        en, v, b, f, h;
    logic [31:0] da;
    logic [4:0]  rd;
    logic [14:0] ctrl;
    logic [31:0] e_da;
    logic [4:0]  e_rd;
    logic [14:0] e_ctrl;
    logic        e_v;
    logic [15:0] e_bc, e_fc;
  } vec_t;

  vec_t tbl[7];
  int en_pat[5];

  initial begin
    // load, 3x stall, bubble, flush+bubble, load of an invalid slot
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, 5'd9, 15'h7FFF,
               32'h12345678, 5'd9, 15'h7FFF, 1'b1, 16'd0, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd31, 15'h0000,
               32'h12345678, 5'd9, 15'h7FFF, 1'b1, 16'd0, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 5'd30, 15'h0001,
               32'h12345678, 5'd9, 15'h7FFF, 1'b1, 16'd0, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0BADC0DE, 5'd29, 15'h0002,
               32'h12345678, 5'd9, 15'h7FFF, 1'b1, 16'd0, 16'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAAAA5555, 5'd4, 15'h7FFF,
               32'h12345678, 5'd9, NOP, 1'b0, 16'd1, 16'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hBBBBBBBB, 5'd7, 15'h7FFF,
               32'h00000000, 5'd0, NOP, 1'b0, 16'd1, 16'd1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000055, 5'd3, 15'h0123,
               32'h00000055, 5'd3, 15'h0123, 1'b0, 16'd1, 16'd1};

    // Reset with every input high
    rst1 = 1'b1; rst2 = 1'b1;
    drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 5'h1F, 15'h7FFF);
    drive2(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 15'h7FFF);
    tick();
    chk("rst_data_A", bus1.o_data_A, 32'd0);
    chk("rst_data_B", bus1.o_data_B, 32'd0);
    chk("rst_imm", bus1.o_imm, 32'd0);
    chk("rst_rd", 32'(bus1.o_rd), 32'd0);
    chk("rst_pc", 32'(bus1.o_pc), 32'd0);
    chk("rst_ctrl", 32'(bus1.o_ctrl), 32'(NOP));
    chk("rst_valid", 32'(bus1.o_valid), 32'd0);
    chk("rst_halt_det", 32'(bus1.o_halt_detected), 32'd0);
    chk("rst_halted", 32'(bus1.o_halted), 32'd0);
    chk("rst_state", 32'(bus1.o_state), 32'd0);
    chk("rst_bubble_cnt", 32'(bus1.o_bubble_count), 32'd0);
    chk("rst_flush_cnt", 32'(bus1.o_flush_count), 32'd0);
    rst1 = 1'b0; rst2 = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      drive1(tbl[i].en, tbl[i].v, tbl[i].b, tbl[i].f, tbl[i].h, tbl[i].da, tbl[i].rd, tbl[i].ctrl);
      tick();
      chk($sformatf("tbl%0d_data_A", i), bus1.o_data_A, tbl[i].e_da);
      chk($sformatf("tbl%0d_rd", i), 32'(bus1.o_rd), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_ctrl", i), 32'(bus1.o_ctrl), 32'(tbl[i].e_ctrl));
      chk($sformatf("tbl%0d_valid", i), 32'(bus1.o_valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_bubble_cnt", i), 32'(bus1.o_bubble_count), 32'(tbl[i].e_bc));
      chk($sformatf("tbl%0d_flush_cnt", i), 32'(bus1.o_flush_count), 32'(tbl[i].e_fc));
    end

    // HALT with a 2-cycle stall inside DRAIN
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000077, 5'd12, 15'h1ABC);
    tick();
    chk("halt_det", 32'(bus1.o_halt_detected), 32'd1);
    chk("halt_valid", 32'(bus1.o_valid), 32'd1);
    chk("halt_ctrl", 32'(bus1.o_ctrl), 32'h1ABC);
    chk("halt_state", 32'(bus1.o_state), 32'd1);
    en_pat = '{1, 0, 0, 1, 1};
    begin
      int nops = 0;
      for (int k = 0; k < 5; k++) begin
        // DRAIN must ignore valid/bubble/flush/halt
        drive1(en_pat[k] != 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h99990000 + k, 5'd20, 15'h7FFF);
        tick();
        if (en_pat[k] != 0) nops++;
        chk($sformatf("drain%0d_state", k), 32'(bus1.o_state), (nops == 3) ? 32'd2 : 32'd1);
        chk($sformatf("drain%0d_halted", k), 32'(bus1.o_halted), (nops == 3) ? 32'd1 : 32'd0);
        chk($sformatf("drain%0d_ctrl", k), 32'(bus1.o_ctrl), (nops == 0) ? 32'h1ABC : 32'(NOP));
        chk($sformatf("drain%0d_valid", k), 32'(bus1.o_valid), (nops == 0) ? 32'd1 : 32'd0);
        chk($sformatf("drain%0d_data_A", k), bus1.o_data_A, 32'h00000077);
        chk($sformatf("drain%0d_flush_cnt", k), 32'(bus1.o_flush_count), 32'd0);
        chk($sformatf("drain%0d_bubble_cnt", k), 32'(bus1.o_bubble_count), 32'd0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44440000 + k, 5'd21, 15'h0F0F);
      tick();
      chk($sformatf("frozen%0d_data_A", k), bus1.o_data_A, 32'h00000077);
      chk($sformatf("frozen%0d_ctrl", k), 32'(bus1.o_ctrl), 32'(NOP));
      chk($sformatf("frozen%0d_state", k), 32'(bus1.o_state), 32'd2);
    end
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    chk("halted_rst_state", 32'(bus1.o_state), 32'd0);
    chk("halted_rst_halted", 32'(bus1.o_halted), 32'd0);

    // Reset in the middle of DRAIN
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000031, 5'd5, 15'h0100);
    tick();
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 15'h0);
    tick();
    chk("middrain_state", 32'(bus1.o_state), 32'd1);
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    chk("middrain_rst_state", 32'(bus1.o_state), 32'd0);
    chk("middrain_rst_data_A", bus1.o_data_A, 32'd0);

    // HALT discarded by a simultaneous flush, then by a bubble
    drive1(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000066, 5'd6, 15'h0111);
    tick();
    chk("halt_flush_state", 32'(bus1.o_state), 32'd0);
    chk("halt_flush_det", 32'(bus1.o_halt_detected), 32'd0);
    chk("halt_flush_cnt", 32'(bus1.o_flush_count), 32'd1);
    drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000067, 5'd7, 15'h0112);
    tick();
    chk("halt_bubble_state", 32'(bus1.o_state), 32'd0);
    chk("halt_bubble_det", 32'(bus1.o_halt_detected), 32'd0);
    chk("halt_bubble_cnt", 32'(bus1.o_bubble_count), 32'd1);

    // Zero drain cycles: HALT freezes the stage immediately
    drive2(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000005, 15'h0F0F);
    tick();
    chk("hdc0_state", 32'(bus2.o_state), 32'd2);
    chk("hdc0_halted", 32'(bus2.o_halted), 32'd1);
    chk("hdc0_halt_det", 32'(bus2.o_halt_detected), 32'd1);
    chk("hdc0_ctrl", 32'(bus2.o_ctrl), 32'h0F0F);
    drive2(1'b1, 1'b1, 1'b0, 1'b0, 32'h00000006, 15'h0000);
    tick();
    chk("hdc0_hold_data_A", bus2.o_data_A, 32'h00000005);

    // Counter saturation on a 4-bit counter
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      drive2(1'b1, 1'b1, 1'b1, 1'b0, 32'(k), 15'h0000);
      tick();
      chk($sformatf("sat%0d_flush_cnt", k), 32'(bus2.o_flush_count), (k > 15) ? 32'd15 : 32'(k));
    end

    // Randomized run against the reference model
    rst1 = 1'b1;
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 15'h0);
    model_edge();
    tick();
    rst1 = 1'b0;
    check_all();
    for (int n = 0; n < 400; n++) begin
      bus1.i_enable_pipeline = ($urandom_range(0, 3) != 0);
      bus1.i_valid  = ($urandom_range(0, 4) != 0);
      bus1.i_bubble = ($urandom_range(0, 5) == 0);
      bus1.i_flush  = ($urandom_range(0, 7) == 0);
      bus1.i_halt   = ($urandom_range(0, 9) == 0);
      bus1.i_data_A = $urandom();
      bus1.i_data_B = $urandom();
      bus1.i_imm    = $urandom();
      bus1.i_rs     = 5'($urandom());
      bus1.i_rt     = 5'($urandom());
      bus1.i_rd     = 5'($urandom());
      bus1.i_pc     = 11'($urandom());
      bus1.i_ctrl   = 15'($urandom());
      rst1 = ((m_mode == 2) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0);
      model_edge();
      tick();
      check_all();
    end
    rst1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_bank.md
# id_ex_pipeline_bank

Parametrised ID/EX pipeline register for the MIPS core, placed between the decode stage and execute. It latches decoded operands, register addresses, PC+1 and a packed control word. Stall, bubble and flush are distinct actions with fixed priority. A halt-drain state machine feeds a configurable number of NOPs behind a HALT, then freezes the stage. Saturating bubble and flush counters are exposed to the debug unit.

## Interface
- CANT_BITS_REGISTROS, 32, data-path width of operands and immediate.
- CANT_BITS_ADDR, 11, PC width.
- CANT_BITS_REG_ADDR, 5, register address width.
- CANT_BITS_CTRL, 15, packed control word width: RegDst, RegWrite, ALUSrc, ALUOp[2], MemRead, MemWrite, MemtoReg, ALUCtrl[4], select_bytes[3].
- NOP_CTRL, 15'b000000000010000, control word inserted on bubble/flush; ALUCtrl=0010, all others 0.
- HALT_DRAIN_CYCLES, 3, NOPs issued after a HALT before freezing; 0 is legal.
- CANT_BITS_CONTADOR, 16, width of the statistics counters.
- i_clock  in  1  clock; all state updates on its falling edge.
- i_soft_reset  in  1  synchronous, active-high reset.
- i_enable_pipeline  in  1  0 = stall: hold every register and the FSM.
- i_valid  in  1  decode slot holds a real instruction.
- i_bubble  in  1  load-use hazard: insert a bubble.
- i_flush  in  1  branch taken in ID: squash the slot.
- i_halt  in  1  decoded instruction is HALT.
- i_data_A, i_data_B, i_imm  in  CANT_BITS_REGISTROS each  operands and sign-extended immediate.
- i_rs, i_rt, i_rd  in  CANT_BITS_REG_ADDR each  register addresses.
- i_pc  in  CANT_BITS_ADDR  PC+1.
- i_ctrl  in  CANT_BITS_CTRL  control word.
- o_data_A, o_data_B, o_imm, o_rs, o_rt, o_rd, o_pc, o_ctrl  out  matching widths  registered copies.
- o_valid  out  1  EX slot holds a real instruction.
- o_halt_detected  out  1  EX slot holds the HALT.
- o_halted  out  1  stage is frozen.
- o_state  out  2  FSM state: RUN=0, DRAIN=1, HALTED=2.
- o_bubble_count, o_flush_count  out  CANT_BITS_CONTADOR each  saturating event counts.

## Operation
- Reset: every output is 0 except o_ctrl, which resets to NOP_CTRL. State goes to RUN.
- Action priority per edge: reset > HALTED hold > stall (enable=0) > DRAIN NOP > flush > bubble > load.
- Load (RUN, enable=1, no flush, no bubble): all fields are copied from the inputs, o_valid<=i_valid, o_halt_detected<=i_valid&i_halt.
- Bubble: data, address and PC fields hold their value. o_ctrl<=NOP_CTRL, o_valid<=0, o_halt_detected<=0. o_bubble_count increments.
- Flush: data, address and PC fields clear to 0. o_ctrl<=NOP_CTRL, o_valid<=0, o_halt_detected<=0. o_flush_count increments.
- Flush and bubble together: only the flush is applied and only the flush counter increments.
- Counters saturate at all-ones and never wrap.
- FSM transitions:
  - RUN: a load with i_valid&i_halt goes to DRAIN with the drain counter set to HALT_DRAIN_CYCLES. If HALT_DRAIN_CYCLES=0 it goes straight to HALTED.
  - A flush or bubble in the same cycle as i_halt discards the HALT; state stays RUN.
  - DRAIN: each enabled edge inserts a NOP (same field behaviour as a bubble, no counter change) and decrements the drain counter. At 1 it goes to HALTED.
  - DRAIN ignores i_valid, i_bubble, i_flush and i_halt.
  - HALTED: all registers hold and o_halted=1. Only reset leaves this state.

## Timing
- Latency is one falling edge from input to output. There are no combinational paths from inputs to outputs.
- Stall in DRAIN freezes the drain counter, so the number of NOPs is exact regardless of stalls.
- HALT loaded at edge N, HALT_DRAIN_CYCLES=3, no stalls:
  - o_halt_detected is 1 after edge N.
  - NOPs are issued at edges N+1 to N+3.
  - o_halted=1 after edge N+3.
- Reset asserted mid-DRAIN or in HALTED returns to RUN at that edge.

## Structure
- A shared package `id_ex_pkg` holds:
  - the control-word bit offsets;
  - NOP_CTRL;
  - the FSM state encodings;
  - ALUCTRL_ADD=4'b0010.
- One sub-module, `sat_counter`, parametrised by width, with inputs i_clock, i_soft_reset, i_inc and output o_count. It is instantiated twice.

## Test plan
- Reset with all inputs driven to 1: every output is 0, o_ctrl=NOP_CTRL, o_state=0.
- Load i_data_A=32'h12345678, i_rd=5'd9, i_ctrl=all-ones, i_valid=1:
  - one edge later the outputs match the inputs and o_valid=1;
  - with enable=0 for 3 edges the outputs hold.
- Bubble, then flush together with bubble:
  - the bubble holds o_data_A and gives o_ctrl=NOP_CTRL, o_bubble_count=1;
  - flush plus bubble zeroes the data fields and gives o_flush_count=1, o_bubble_count=1.
- HALT with HALT_DRAIN_CYCLES=3 and a 2-cycle stall inside DRAIN:
  - exactly 3 NOPs are issued;
  - o_halted=1 after 6 edges;
  - later inputs are ignored.
- HALT arriving together with a flush: state stays 0 and o_halt_detected=0.
- Force o_flush_count to 16'hFFFF, then apply one more flush: the count stays 16'hFFFF.
